firing_dispatch_ctrl: RTL and testbench
=======================================

FIRING_DISPATCH_CTRL -- requirements
Module: firing_dispatch_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WORD_SIZE, 16, token width; SHALL be at least 16.
- N_MODES, 4, number of attached mode sub-FSMs.
- OPC_W, 8, opcode field width.
- TIMEOUT, 1024, WAIT-cycle limit before a timeout error.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- rst, in, 1, asynchronous, active-high reset.
- start_fire, in, 1, firing request from the parent FSM.
- done_fire, out, 1, one-cycle firing-complete pulse.
- cmd_empty, in, 1, command FIFO empty flag.
- cmd_rd_en, out, 1, command FIFO read strobe.
- cmd_in, in, WORD_SIZE, command FIFO data, valid 1 cycle after cmd_rd_en.
- mode_start, out, N_MODES, one-hot start pulse to a mode sub-FSM.
- mode_done, in, N_MODES, per-mode done pulse.
- mode_tok_valid, in, N_MODES, per-mode intermediate-token strobe.
- mode_result, in, N_MODES*WORD_SIZE, packed per-mode result.
- mode_status, in, N_MODES*WORD_SIZE, packed per-mode status.
- arg1, out, 3, decoded argument 1, held per firing.
- arg2, out, 5, decoded argument 2, held per firing.
- out_full, in, 1, output FIFO full flag.
- out_wr_en, out, 1, output FIFO write strobe (result and status together).
- result_out, out, WORD_SIZE, result token.
- status_out, out, WORD_SIZE, status token.

Function
REQ-003 Command word fields: opcode = cmd_in[15:8], arg1 = cmd_in[7:5], arg2 = cmd_in[4:0]; the upper bits are ignored.
REQ-004 States: IDLE, FETCH, DECODE, START, WAIT, OUTPUT, DONE.
REQ-005 IDLE -> FETCH when start_fire=1 and cmd_empty=0; otherwise the FSM stays in IDLE. start_fire with cmd_empty=1 is ignored and does not produce done_fire.
REQ-006 FETCH asserts cmd_rd_en for exactly one cycle, then goes to DECODE.
REQ-007 DECODE latches the opcode, arg1 and arg2.
- If opcode < N_MODES: go to START.
- Otherwise: load result_out=0 and status_out=1 (bad opcode), then go to OUTPUT with the final flag set.
REQ-008 START drives mode_start one-hot at bit [opcode] for exactly one cycle, clears the watchdog, then goes to WAIT.
REQ-009 WAIT samples only the selected mode's inputs and increments the watchdog each cycle.
- mode_done=1: capture result/status, set final, go to OUTPUT.
- Else mode_tok_valid=1: capture result/status, clear final, go to OUTPUT.
- Else watchdog = TIMEOUT-1: load result 0 and status 2, set final, go to OUTPUT.
REQ-010 When mode_done and mode_tok_valid are asserted in the same cycle, done wins and exactly one token is emitted.
REQ-011 OUTPUT holds result_out/status_out stable while out_full=1. It asserts out_wr_en for exactly one cycle once out_full=0, then goes to DONE if final is set, else back to WAIT. The watchdog is frozen in OUTPUT and cleared on return to WAIT.
REQ-012 DONE asserts done_fire for one cycle, then goes to IDLE.
REQ-013 Success status is the mode's own status word, passed through unchanged; the block produces only codes 1 (bad opcode) and 2 (timeout).
REQ-014 Minimum firing latency, start_fire to done_fire with a 1-cycle mode and out_full=0: 6 cycles.
REQ-015 mode_done/mode_tok_valid on non-selected bits, or outside WAIT, SHALL be ignored.
REQ-016 All outputs are registered; out_wr_en, cmd_rd_en, mode_start and done_fire are never asserted for more than one cycle per event.

Reset
REQ-017 rst=1 asynchronously forces IDLE, clears the watchdog and final flag, and sets every output to 0.
REQ-018 rst mid-firing abandons the firing with no output token and no done_fire; after deassertion the block waits in IDLE for a new start_fire.

Structure
REQ-019 A shared package holds the state encoding, the status codes (OK passthrough, BAD_OPC=1, TIMEOUT=2) and the command field bit positions.
REQ-020 The watchdog is a natural sub-module, fire_watchdog (clear, enable, expired at TIMEOUT-1); everything else is one FSM with datapath registers.

Verification
REQ-021 Directed scenarios:
- Cmd 0x0123, mode 1 done after 3 cycles with result 0x00AA, status 0 -> mode_start=0010; arg1=1, arg2=3; one write 0x00AA/0; done_fire.
- Opcode 0x07, N_MODES=4 -> no mode_start; one write 0/1; done_fire.
- Mode 2 gives tok_valid twice, then done -> exactly three writes in order, one done_fire.
- Mode never finishes, TIMEOUT=16 -> after 16 WAIT cycles one write 0/2, then done_fire.
- out_full=1 for 5 cycles in OUTPUT -> result held, out_wr_en only after full drops, one write.
- rst pulse during WAIT -> all outputs 0, no write; next firing completes normally.

Source files
------------

// File: rtl/firing_dispatch_ctrl_pkg.sv
// Shared definitions for the firing dispatch controller.
//   state_t       : dispatch FSM state encoding
//   STATUS_*      : status codes the controller generates itself
//                   (a mode's own status word is passed through unchanged)
//   *_LSB / *_W   : bit positions of the command word fields
package firing_dispatch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_START,
        ST_WAIT,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    localparam int STATUS_BAD_OPC = 1;
    localparam int STATUS_TIMEOUT = 2;

    // Command word: opcode = [15:8], arg1 = [7:5], arg2 = [4:0].
    localparam int OPC_LSB  = 8;
    localparam int ARG1_LSB = 5;
    localparam int ARG1_W   = 3;
    localparam int ARG2_LSB = 0;
    localparam int ARG2_W   = 5;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fire_watchdog.sv
// WAIT-cycle watchdog for the firing dispatch controller.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : synchronous clear of the count (wins over enable_i)
//   enable_i   : count one cycle
//   expired_o  : count has reached TIMEOUT-1
module fire_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/firing_dispatch_ctrl.sv
// Firing dispatch controller: fetches one command word, decodes it, starts
// the selected mode sub-FSM and forwards its tokens to the output FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   start_fire      : firing request; done_fire pulses when the firing ends
//   cmd_empty/rd_en : command FIFO; cmd_in is valid the cycle after cmd_rd_en
//   mode_*          : one-hot start pulse out, per-mode done/token/result/status in
//   arg1, arg2      : decoded arguments, held for the whole firing
//   out_full/wr_en  : output FIFO; result_out and status_out written together
//
// Strobe semantics: cmd_rd_en, mode_start, out_wr_en and done_fire are
// single-cycle registered pulses, one per event. out_full is sampled while in
// OUTPUT; the write pulse appears the cycle after out_full was seen low, and
// result_out/status_out stay stable from entry to OUTPUT through that pulse.
module firing_dispatch_ctrl
    import firing_dispatch_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int N_MODES   = 4,
    parameter int OPC_W     = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_fire,
    output logic                           done_fire,
    input  logic                           cmd_empty,
    output logic                           cmd_rd_en,
    input  logic [WORD_SIZE-1:0]           cmd_in,
    output logic [N_MODES-1:0]             mode_start,
    input  logic [N_MODES-1:0]             mode_done,
    input  logic [N_MODES-1:0]             mode_tok_valid,
    input  logic [N_MODES*WORD_SIZE-1:0]   mode_result,
    input  logic [N_MODES*WORD_SIZE-1:0]   mode_status,
    output logic [ARG1_W-1:0]              arg1,
    output logic [ARG2_W-1:0]              arg2,
    input  logic                           out_full,
    output logic                           out_wr_en,
    output logic [WORD_SIZE-1:0]           result_out,
    output logic [WORD_SIZE-1:0]           status_out
);

    localparam int IDX_W = idx_width(N_MODES);

    state_t                 state_q;
    logic [IDX_W-1:0]       sel_q;
    logic                   final_q;
    logic                   done_fire_q;
    logic                   cmd_rd_en_q;
    logic [N_MODES-1:0]     mode_start_q;
    logic [ARG1_W-1:0]      arg1_q;
    logic [ARG2_W-1:0]      arg2_q;
    logic                   out_wr_en_q;
    logic [WORD_SIZE-1:0]   result_q;
    logic [WORD_SIZE-1:0]   status_q;

    // Decode view of the command word (meaningful only in DECODE).
    logic [OPC_W-1:0]       dec_opc;
    logic [IDX_W-1:0]       dec_sel;
    logic                   dec_opc_ok;

    assign dec_opc    = cmd_in[OPC_LSB +: OPC_W];
    assign dec_sel    = dec_opc[IDX_W-1:0];
    assign dec_opc_ok = (32'(dec_opc) < 32'(N_MODES));

    // Only the selected mode's inputs are looked at; others are ignored.
    logic                   sel_done;
    logic                   sel_tok;
    logic [WORD_SIZE-1:0]   sel_result;
    logic [WORD_SIZE-1:0]   sel_status;

    always_comb begin
        sel_done   = 1'b0;
        sel_tok    = 1'b0;
        sel_result = '0;
        sel_status = '0;
        for (int m = 0; m < N_MODES; m++) begin
            if (IDX_W'(m) == sel_q) begin
                sel_done   = mode_done[m];
                sel_tok    = mode_tok_valid[m];
                sel_result = mode_result[m*WORD_SIZE +: WORD_SIZE];
                sel_status = mode_status[m*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Watchdog counts WAIT cycles; it is restarted when a mode is started and
    // again when an intermediate token has been written and WAIT resumes.
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign wd_clear  = (state_q == ST_START) ||
                       ((state_q == ST_OUTPUT) && !out_full && !final_q);
    assign wd_enable = (state_q == ST_WAIT);

    fire_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            final_q      <= 1'b0;
            done_fire_q  <= 1'b0;
            cmd_rd_en_q  <= 1'b0;
            mode_start_q <= '0;
            arg1_q       <= '0;
            arg2_q       <= '0;
            out_wr_en_q  <= 1'b0;
            result_q     <= '0;
            status_q     <= '0;
        end else begin
            // Pulse outputs default low; states below raise them for one cycle.
            done_fire_q  <= 1'b0;
            cmd_rd_en_q  <= 1'b0;
            mode_start_q <= '0;
            out_wr_en_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start_fire && !cmd_empty) begin
                        cmd_rd_en_q <= 1'b1;
                        state_q     <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    state_q <= ST_DECODE;
                end

                ST_DECODE: begin
                    arg1_q <= cmd_in[ARG1_LSB +: ARG1_W];
                    arg2_q <= cmd_in[ARG2_LSB +: ARG2_W];
                    sel_q  <= dec_sel;
                    if (dec_opc_ok) begin
                        mode_start_q <= N_MODES'(1) << dec_sel;
                        state_q      <= ST_START;
                    end else begin
                        result_q <= '0;
                        status_q <= WORD_SIZE'(STATUS_BAD_OPC);
                        final_q  <= 1'b1;
                        state_q  <= ST_OUTPUT;
                    end
                end

                ST_START: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Done outranks a simultaneous token: one write, then finish.
                    if (sel_done) begin
                        result_q <= sel_result;
                        status_q <= sel_status;
                        final_q  <= 1'b1;
                        state_q  <= ST_OUTPUT;
                    end else if (sel_tok) begin
                        result_q <= sel_result;
                        status_q <= sel_status;
                        final_q  <= 1'b0;
                        state_q  <= ST_OUTPUT;
                    end else if (wd_expired) begin
                        result_q <= '0;
                        status_q <= WORD_SIZE'(STATUS_TIMEOUT);
                        final_q  <= 1'b1;
                        state_q  <= ST_OUTPUT;
                    end
                end

                ST_OUTPUT: begin
                    if (!out_full) begin
                        out_wr_en_q <= 1'b1;
                        if (final_q) begin
                            done_fire_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q     <= ST_WAIT;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done_fire  = done_fire_q;
    assign cmd_rd_en  = cmd_rd_en_q;
    assign mode_start = mode_start_q;
    assign arg1       = arg1_q;
    assign arg2       = arg2_q;
    assign out_wr_en  = out_wr_en_q;
    assign result_out = result_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_firing_dispatch_ctrl.sv
// Directed bench for firing_dispatch_ctrl. Stimulus pushes expected output
// tokens {result, status} into exp_q; the monitor pops one per out_wr_en.
module tb_firing_dispatch_ctrl;

    localparam int WS = 16;
    localparam int NM = 4;
    localparam int W  = 2 * WS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               start_fire = 1'b0;
    logic               done_fire;
    logic               cmd_empty = 1'b1;
    logic               cmd_rd_en;
    logic [WS-1:0]      cmd_in = '0;
    logic [NM-1:0]      mode_start;
    logic [NM-1:0]      mode_done = '0;
    logic [NM-1:0]      mode_tok_valid = '0;
    logic [NM*WS-1:0]   mode_result = '0;
    logic [NM*WS-1:0]   mode_status = '0;
    logic [2:0]         arg1;
    logic [4:0]         arg2;
    logic               out_full = 1'b0;
    logic               out_wr_en;
    logic [WS-1:0]      result_out;
    logic [WS-1:0]      status_out;

    firing_dispatch_ctrl #(
        .WORD_SIZE (WS),
        .N_MODES   (NM),
        .OPC_W     (8),
        .TIMEOUT   (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_fire     (start_fire),
        .done_fire      (done_fire),
        .cmd_empty      (cmd_empty),
        .cmd_rd_en      (cmd_rd_en),
        .cmd_in         (cmd_in),
        .mode_start     (mode_start),
        .mode_done      (mode_done),
        .mode_tok_valid (mode_tok_valid),
        .mode_result    (mode_result),
        .mode_status    (mode_status),
        .arg1           (arg1),
        .arg2           (arg2),
        .out_full       (out_full),
        .out_wr_en      (out_wr_en),
        .result_out     (result_out),
        .status_out     (status_out)
    );

    // Command FIFO model: data appears the cycle after the read strobe.
    logic [WS-1:0] cmd_data = '0;
    always @(posedge clk) begin
        if (cmd_rd_en) cmd_in <= cmd_data;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int ms_seen = 0;
    logic wr_prev = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mode_start != '0) ms_seen++;
            if (out_wr_en) begin
                if (wr_prev) begin
                    errors++;
                    $display("FAIL wr_pulse_width actual=2+ cycles required=1");
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=%h/%h required=none", result_out, status_out);
                end else begin
                    check("write_token", {result_out, status_out}, exp_q.pop_front());
                end
            end
            wr_prev <= out_wr_en;
        end else begin
            wr_prev <= 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests a firing; returns with the FSM in FETCH.
    task automatic fire(input logic [WS-1:0] cmd);
        cmd_data   = cmd;
        cmd_empty  = 1'b0;
        start_fire = 1'b1;
        tick();
        start_fire = 1'b0;
        cmd_empty  = 1'b1;
    endtask

    // Waits for mode_start, checks it, then returns in the first WAIT cycle.
    task automatic wait_mode_start(input string name, input logic [NM-1:0] exp);
        for (int i = 0; i < 8 && mode_start == '0; i++) tick();
        check(name, W'(mode_start), W'(exp));
        tick();
        check({name, "_pulse"}, W'(mode_start), '0);
    endtask

    // Drives one mode response for one cycle.
    task automatic drive_mode(input int m, input logic d, input logic t,
                              input logic [WS-1:0] res, input logic [WS-1:0] st);
        mode_result[m*WS +: WS] = res;
        mode_status[m*WS +: WS] = st;
        mode_done[m]      = d;
        mode_tok_valid[m] = t;
        tick();
        mode_done      = '0;
        mode_tok_valid = '0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 30 && !done_fire; i++) tick();
        check(name, W'(done_fire), W'(1));
        tick();
        check({name, "_pulse"}, W'(done_fire), '0);
    endtask

    task automatic scenario_basic();
        fire(16'h0123);
        wait_mode_start("s1_mode_start", 4'b0010);
        check("s1_arg1", W'(arg1), W'(1));
        check("s1_arg2", W'(arg2), W'(3));
        tick();
        tick();
        exp_q.push_back({16'h00AA, 16'h0000});
        drive_mode(1, 1'b1, 1'b0, 16'h00AA, 16'h0000);
        wait_done("s1_done");
    endtask

    // ---------------- test sequence ----------------
    int base_ms;
    int lat;
    int k;
    logic got;
    logic armed;

    initial begin
        tick();
        tick();
        check("rst_done_fire",  W'(done_fire),  '0);
        check("rst_cmd_rd_en",  W'(cmd_rd_en),  '0);
        check("rst_mode_start", W'(mode_start), '0);
        check("rst_out_wr_en",  W'(out_wr_en),  '0);
        check("rst_args",       W'({arg1, arg2}), '0);
        check("rst_tokens",     {result_out, status_out}, '0);
        rst = 1'b0;
        tick();

        // start_fire with an empty command FIFO is ignored
        start_fire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("empty_no_rd", W'(cmd_rd_en), '0);
            check("empty_no_done", W'(done_fire), '0);
        end
        start_fire = 1'b0;
        tick();

        // mode 1, done after a few cycles
        scenario_basic();

        // bad opcode 0x07, arg1=7 arg2=5
        base_ms = ms_seen;
        exp_q.push_back({16'h0000, 16'h0001});
        fire(16'h07E5);
        wait_done("s2_done");
        check("s2_no_mode_start", W'(ms_seen - base_ms), '0);
        check("s2_arg1", W'(arg1), W'(7));
        check("s2_arg2", W'(arg2), W'(5));

        // mode 2: two tokens, stray done from mode 0, then done+token together
        fire(16'h0245);
        wait_mode_start("s3_mode_start", 4'b0100);
        exp_q.push_back({16'h1111, 16'h0011});
        drive_mode(2, 1'b0, 1'b1, 16'h1111, 16'h0011);
        tick();
        tick();
        exp_q.push_back({16'h2222, 16'h0022});
        drive_mode(2, 1'b0, 1'b1, 16'h2222, 16'h0022);
        tick();
        drive_mode(0, 1'b1, 1'b1, 16'hDEAD, 16'hDEAD);
        tick();
        exp_q.push_back({16'h3333, 16'h0033});
        drive_mode(2, 1'b1, 1'b1, 16'h3333, 16'h0033);
        wait_done("s3_done");

        // mode 3 never answers: timeout after 16 WAIT cycles
        fire(16'h0300);
        wait_mode_start("s4_mode_start", 4'b1000);
        exp_q.push_back({16'h0000, 16'h0002});
        k = 0;
        while (!out_wr_en && k < 40) begin
            tick();
            k++;
        end
        check("s4_timeout_cycles", W'(k), W'(17));
        check("s4_done_with_write", W'(done_fire), W'(1));
        tick();

        // output FIFO full while the token waits
        out_full = 1'b1;
        fire(16'h0000);
        wait_mode_start("s5_mode_start", 4'b0001);
        exp_q.push_back({16'hBEEF, 16'h0005});
        drive_mode(0, 1'b1, 1'b0, 16'hBEEF, 16'h0005);
        for (int i = 0; i < 5; i++) begin
            check("s5_no_write_full", W'(out_wr_en), '0);
            check("s5_held", {result_out, status_out}, {16'hBEEF, 16'h0005});
            tick();
        end
        out_full = 1'b0;
        wait_done("s5_done");

        // minimum latency with a 1-cycle mode
        cmd_data = 16'h0101;
        mode_result[1*WS +: WS] = 16'h0F0F;
        mode_status[1*WS +: WS] = 16'h0000;
        exp_q.push_back({16'h0F0F, 16'h0000});
        lat = 0; got = 1'b0; armed = 1'b0;
        start_fire = 1'b1;
        cmd_empty  = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            start_fire = 1'b0;
            cmd_empty  = 1'b1;
            mode_done  = '0;
            if (armed) begin
                mode_done[1] = 1'b1;
                armed = 1'b0;
            end
            if (mode_start[1]) armed = 1'b1;
            if (done_fire) got = 1'b1;
        end
        mode_done = '0;
        check("latency", W'(lat), W'(6));
        tick();

        // reset during WAIT abandons the firing
        fire(16'h01E3);
        wait_mode_start("s6_mode_start", 4'b0010);
        tick();
        rst = 1'b1;
        #1;
        check("s6_rst_args",   W'({arg1, arg2}), '0);
        check("s6_rst_tokens", {result_out, status_out}, '0);
        check("s6_rst_pulses", W'({done_fire, cmd_rd_en, mode_start, out_wr_en}), '0);
        tick();
        rst = 1'b0;
        drive_mode(1, 1'b1, 1'b1, 16'h5555, 16'h5555);
        for (int i = 0; i < 5; i++) begin
            check("s6_idle_no_done", W'(done_fire), '0);
            tick();
        end
        scenario_basic();

        for (int i = 0; i < 4; i++) tick();
        check("exp_q_drained", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
